// File: rtl/counter_pkg.sv
// counter_pkg: shared direction and mode encodings for the counter family
package counter_pkg;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: enable-gated prescaler producing one tick every prescale+1 enabled cycles
module tick_gen #(
    parameter int prescale_bits = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     restart,
    input  logic [prescale_bits-1:0] prescale,
    output logic                     tick
);
    localparam logic [prescale_bits-1:0] one = 1;
    logic [prescale_bits-1:0] psc;

    assign tick = en && (psc == prescale);

    // psc only returns to 0 on an exact match, so a lowered prescale free-runs to the top and wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) psc <= '0;
        else if (restart) psc <= '0;
        else if (en) psc <= (psc == prescale) ? '0 : psc + one;
    end
endmodule

// File: rtl/prog_counter.sv
// prog_counter: up/down counter with programmable limit, wrap/saturate, prescaler and overflow flag
module prog_counter
    import counter_pkg::*;
#(
    parameter int bits          = 8,
    parameter int prescale_bits = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     load,
    input  logic [bits-1:0]          load_val,
    input  logic                     up,
    input  logic                     mode,
    input  logic [bits-1:0]          limit,
    input  logic [prescale_bits-1:0] prescale,
    output logic [bits-1:0]          count,
    output logic                     done,
    output logic                     tc_pulse,
    output logic                     ovf
);
    localparam logic [bits-1:0] one = 1;
    logic            tick;
    logic            term;
    logic [bits-1:0] step_val;

    tick_gen #(.prescale_bits(prescale_bits)) u_tick (
        .clk(clk),
        .rst(rst),
        .en(en),
        .restart(clr | load),
        .prescale(prescale),
        .tick(tick)
    );

    assign term = (up == DIR_UP) ? (count >= limit) : (count == '0);
    assign done = term;

    // next count for a tick, including the wrap/saturate value at the terminal point
    always_comb begin
        step_val = (up == DIR_UP)
            ? (term ? ((mode == MODE_SAT) ? limit : '0) : count + one)
            : (term ? ((mode == MODE_SAT) ? '0 : limit) : count - one);
    end

    // count, pulse and sticky flag with priority clr > load > tick > hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            tc_pulse <= 1'b0;
            ovf      <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            tc_pulse <= 1'b0;
            ovf      <= 1'b0;
        end else if (load) begin
            count    <= load_val;
            tc_pulse <= 1'b0;
        end else if (tick) begin
            count    <= step_val;
            tc_pulse <= term;
            ovf      <= ovf | term;
        end else begin
            tc_pulse <= 1'b0;
        end
    end
endmodule
